shift_seq_ctrl: RTL

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences an external 8-bit combinational shifter over one
// or more passes of at most 7 bits each, so shift totals of 0..15 are reached
// by repeated partial shifts of a work register. The final value is presented
// on dout with a one-cycle done pulse.

module shift_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic [3:0] amt,
    input  logic       dir,
    output logic [7:0] sh_in,
    output logic [2:0] sh_amt,
    output logic       sh_lr,
    input  logic [7:0] sh_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] work_q,  work_d;
    logic [3:0] rem_q,   rem_d;
    logic       dir_q,   dir_d;
    logic [7:0] dout_q,  dout_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic [2:0] pass_amt;
    logic [3:0] rem_next;

    // Per-pass amount: a full 7-bit pass while more than 7 remain, else the rest.
    always_comb begin
        pass_amt = 3'd0;
        if (state_q == SHIFT) begin
            pass_amt = (rem_q > 4'd7) ? 3'd7 : rem_q[2:0];
        end
    end

    // pass_amt never exceeds rem_q, so this subtraction cannot wrap.
    assign rem_next = rem_q - {1'b0, pass_amt};

    // Next-state and next-output logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = SHIFT;
                    work_d  = din;
                    rem_d   = amt;
                    dir_d   = dir;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                work_d = sh_out;
                rem_d  = rem_next;
                busy_d = 1'b1;
                if (rem_next == 4'd0) begin
                    state_d = DONE;
                    dout_d  = sh_out;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state, including the registered busy/done outputs, with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 8'h00;
            rem_q   <= 4'd0;
            dir_q   <= 1'b0;
            dout_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sh_in  = work_q;
    assign sh_amt = pass_amt;
    assign sh_lr  = ~dir_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign dout   = dout_q;

endmodule
